// File: rtl/button_reader.sv
// Push-button front end: two-flop synchroniser, debounce filter and a
// press-duration classifier producing level, press/release and short/long pulses.
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int LONG_CYCLES     = 25_000_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

    state_t            state;
    logic              s1, s2;
    logic              raw;
    logic              db_done, acc_press, acc_release;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    // raw is 1 whenever the button is physically pressed, whatever the pin polarity.
    assign raw         = s2 ^ ACTIVE_LOW;
    assign db_done     = (raw != level_o) && (db_cnt == DB_LAST);
    assign acc_press   = db_done && raw;
    assign acc_release = db_done && !raw;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1      <= ACTIVE_LOW;
            s2      <= ACTIVE_LOW;
            level_o <= 1'b0;
            db_cnt  <= '0;
        end else begin
            s1 <= btn_i;
            s2 <= s1;
            if (raw == level_o) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level_o <= raw;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Release is checked before the long threshold so a coincident release wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc_press) begin
                        state    <= PRESSED;
                        hold_cnt <= '0;
                        press_o  <= 1'b1;
                    end
                end
                PRESSED: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (acc_release) begin
                        state     <= IDLE;
                        release_o <= 1'b1;
                        short_o   <= 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state  <= LONG_HELD;
                        long_o <= 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (acc_release) begin
                        state     <= IDLE;
                        release_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: expected pulses are queued with their
// edge number when the pin is driven and compared when that edge comes round.
module tb_button_reader;
    localparam int DB = 4;
    localparam int LG = 20;
    localparam logic [3:0] EV_P = 4'b1000;  // {press, release, short, long}
    localparam logic [3:0] EV_R = 4'b0100;
    localparam logic [3:0] EV_S = 4'b0010;
    localparam logic [3:0] EV_L = 4'b0001;

    typedef struct {
        logic [3:0] val;
        int         edge_n;
    } ev_t;

    logic clk, rst, btn;
    logic level, press, rel, shrt, lng;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   pe = 0;
    logic rst_seen = 1'b0;
    logic exp_level = 1'b0;
    bit   done = 1'b0;
    logic [3:0] obs, want;
    ev_t  sb[$];

    button_reader #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .ACTIVE_LOW(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .btn_i(btn),
        .level_o(level), .press_o(press), .release_o(rel),
        .short_o(shrt), .long_o(lng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s @edge %0d: got=%0h want=%0h", tag, cyc, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sb_push(input logic [3:0] v, input int e);
        ev_t ev;
        ev.val    = v;
        ev.edge_n = e;
        sb.push_back(ev);
    endtask

    // Pin goes pressed after edge cyc; acceptance lands DB+2 edges later.
    task automatic drive_press();
        btn = 1'b0;
        pe  = cyc + DB + 2;
        sb_push(EV_P, pe);
    endtask

    task automatic drive_release();
        int acc;
        acc = cyc + DB + 2;
        btn = 1'b1;
        if (acc <= pe + LG) sb_push(EV_R | EV_S, acc);
        else sb_push(EV_R, acc);
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    always @(negedge clk) begin
        obs = {press, rel, shrt, lng};
        if (rst_seen) begin
            chk("reset_pulses", {28'd0, obs}, 32'd0);
            chk("reset_level", {31'd0, level}, 32'd0);
            exp_level = 1'b0;
        end else begin
            want = 4'b0000;
            if (sb.size() > 0 && sb[0].edge_n < cyc) begin
                chk("sb_stale", cyc, sb[0].edge_n);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].edge_n == cyc) begin
                want = sb[0].val;
                void'(sb.pop_front());
            end
            if (obs != 4'b0000 || want != 4'b0000) chk("pulses", {28'd0, obs}, {28'd0, want});
            if (want[3]) exp_level = 1'b1;
            else if (want[2]) exp_level = 1'b0;
            chk("level", {31'd0, level}, {31'd0, exp_level});
        end
        if (done) begin
            chk("sb_empty", sb.size(), 32'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        rst = 1'b1;
        btn = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();

        // clean press, released 10 cycles after press_o -> short
        drive_press();
        repeat (DB + 2 + 10) tick();
        drive_release();
        repeat (15) tick();

        // bounce: 3 low, 1 high, 3 low, 1 high, then steady low
        btn = 1'b0;
        repeat (3) tick();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        repeat (3) tick();
        btn = 1'b1;
        tick();
        drive_press();
        repeat (16) tick();
        drive_release();
        repeat (15) tick();

        // long hold, release well after the threshold
        drive_press();
        sb_push(EV_L, pe + LG);
        repeat (40) tick();
        drive_release();
        repeat (15) tick();

        // release accepted exactly on the long threshold edge: release wins
        drive_press();
        repeat (LG) tick();
        drive_release();
        repeat (15) tick();

        // release accepted one edge after the threshold
        drive_press();
        sb_push(EV_L, pe + LG);
        repeat (LG + 1) tick();
        drive_release();
        repeat (15) tick();

        // reset mid-hold with the button kept down, then re-detection
        drive_press();
        repeat (16) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_press();
        sb_push(EV_L, pe + LG);
        repeat (40) tick();
        drive_release();
        repeat (15) tick();

        done = 1'b1;
        repeat (5) tick();
        $fatal(1, "FAIL watchdog: summary not reached");
    end
endmodule
